// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   state_t        : controller FSM states (RUN, MD_WAIT)
//   CNT_W_DEF      : default width of the performance counters
//   MD_TIMEOUT_DEF : default number of MD_WAIT cycles before a multdiv
//                    operation is abandoned
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam int CNT_W_DEF      = 16;
  localparam int MD_TIMEOUT_DEF = 40;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Ports:
//   clock : system clock, rising edge
//   clr   : synchronous clear (highest priority)
//   inc   : count one event this cycle; holds at all-ones once reached
//   count : current counter value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for a 5-stage pipeline with a multi-cycle
// multiply/divide unit in X.
// Ports:
//   clock, reset        : system clock; synchronous active-high reset
//   stall_lw            : load-use hazard between X-stage lw and D-stage insn
//   redirect_x          : taken branch / jump resolved in X
//   md_insn_x           : X-stage instruction is a mul or div
//   md_ready            : one-cycle pulse, multdiv result valid
//   pc_we..mw_we        : write enables for PC and pipeline latches
//   fd_nop..xm_nop      : force a nop into the latch on write
//   md_start            : one-cycle multdiv start pulse
//   md_result_sel       : XM captures the multdiv result instead of the ALU
//   md_timeout          : sticky, a multdiv operation was abandoned
//   stall_count         : saturating count of cycles with pc_we=0
//   flush_count         : saturating count of cycles with fd_nop=1
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall_lw,
  input  logic             redirect_x,
  input  logic             md_insn_x,
  input  logic             md_ready,
  output logic             pc_we,
  output logic             fd_we,
  output logic             dx_we,
  output logic             xm_we,
  output logic             mw_we,
  output logic             fd_nop,
  output logic             dx_nop,
  output logic             xm_nop,
  output logic             md_start,
  output logic             md_result_sel,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              timeout_hit;
  logic              timeout_flag;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (timeout_hit) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  // Outputs are Mealy: decoded from the current state and this cycle's
  // hazard inputs. During reset the pipeline free-runs with no bubbles.
  always_comb begin
    pc_we         = 1'b1;
    fd_we         = 1'b1;
    dx_we         = 1'b1;
    xm_we         = 1'b1;
    mw_we         = 1'b1;
    fd_nop        = 1'b0;
    dx_nop        = 1'b0;
    xm_nop        = 1'b0;
    md_start      = 1'b0;
    md_result_sel = 1'b0;
    timeout_hit   = 1'b0;
    state_next    = state;
    wait_cnt_next = wait_cnt;

    if (!reset) begin
      case (state)
        RUN: begin
          if (md_insn_x) begin
            // Launch the multdiv and hold the front end; the instruction
            // stays in DX while a bubble moves into XM.
            md_start      = 1'b1;
            pc_we         = 1'b0;
            fd_we         = 1'b0;
            dx_we         = 1'b0;
            xm_nop        = 1'b1;
            wait_cnt_next = '0;
            state_next    = MD_WAIT;
          end else if (redirect_x) begin
            // Squash the two younger instructions in F/D and D/X.
            fd_nop = 1'b1;
            dx_nop = 1'b1;
          end else if (stall_lw) begin
            pc_we  = 1'b0;
            fd_we  = 1'b0;
            dx_nop = 1'b1;
          end
        end

        MD_WAIT: begin
          if (md_ready) begin
            // A result on the final cycle still beats the timeout.
            md_result_sel = 1'b1;
            state_next    = RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            // Abandon the operation: release the pipeline with a bubble in XM.
            xm_nop      = 1'b1;
            timeout_hit = 1'b1;
            state_next  = RUN;
          end else begin
            pc_we         = 1'b0;
            fd_we         = 1'b0;
            dx_we         = 1'b0;
            xm_nop        = 1'b1;
            wait_cnt_next = wait_cnt + WAIT_W'(1);
          end
        end

        default: state_next = RUN;
      endcase
    end
  end

  // The flag is visible in the cycle the timeout is taken, then held.
  assign md_timeout = timeout_flag | timeout_hit;

  sat_counter #(.W(CNT_W)) u_stall_count (
    .clock (clock),
    .clr   (reset),
    .inc   (~pc_we),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_count (
    .clock (clock),
    .clr   (reset),
    .inc   (fd_nop),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: default-parameter instance plus a
// CNT_W=4 instance for counter saturation.
module tb_pipe_stall_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic stall_lw = 1'b0, redirect_x = 1'b0, md_insn_x = 1'b0, md_ready = 1'b0;
  logic pc_we, fd_we, dx_we, xm_we, mw_we, fd_nop, dx_nop, xm_nop;
  logic md_start, md_result_sel, md_timeout;
  logic [15:0] stall_count, flush_count;

  logic stall_lw4 = 1'b0;
  logic pc_we4, fd_we4, dx_we4, xm_we4, mw_we4, fd_nop4, dx_nop4, xm_nop4;
  logic md_start4, md_result_sel4, md_timeout4;
  logic [3:0] stall_count4, flush_count4;

  logic [4:0] en;
  logic [2:0] nops;
  assign en   = {pc_we, fd_we, dx_we, xm_we, mw_we};
  assign nops = {fd_nop, dx_nop, xm_nop};

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pipe_stall_ctrl dut (
    .clock(clock), .reset(reset), .stall_lw(stall_lw), .redirect_x(redirect_x),
    .md_insn_x(md_insn_x), .md_ready(md_ready),
    .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .xm_we(xm_we), .mw_we(mw_we),
    .fd_nop(fd_nop), .dx_nop(dx_nop), .xm_nop(xm_nop),
    .md_start(md_start), .md_result_sel(md_result_sel), .md_timeout(md_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipe_stall_ctrl #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .stall_lw(stall_lw4), .redirect_x(1'b0),
    .md_insn_x(1'b0), .md_ready(1'b0),
    .pc_we(pc_we4), .fd_we(fd_we4), .dx_we(dx_we4), .xm_we(xm_we4), .mw_we(mw_we4),
    .fd_nop(fd_nop4), .dx_nop(dx_nop4), .xm_nop(xm_nop4),
    .md_start(md_start4), .md_result_sel(md_result_sel4), .md_timeout(md_timeout4),
    .stall_count(stall_count4), .flush_count(flush_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then applied and
  // a further #1 lets combinational outputs settle before checking.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    stall_lw = 1'b0; redirect_x = 1'b0; md_insn_x = 1'b0; md_ready = 1'b0;
    stall_lw4 = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    // Reset: outputs forced, even with a mul/div request present.
    clear_inputs();
    md_insn_x = 1'b1;
    stall_lw  = 1'b1;
    #1;
    next_cycle();
    #1;
    chk("rst_en", 32'(en), 32'h1f);
    chk("rst_nops", 32'(nops), 32'h0);
    chk("rst_md_start", 32'(md_start), 32'h0);
    chk("rst_sel", 32'(md_result_sel), 32'h0);
    next_cycle();
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("post_rst_stall_cnt", 32'(stall_count), 32'h0);
    chk("post_rst_flush_cnt", 32'(flush_count), 32'h0);
    chk("post_rst_timeout", 32'(md_timeout), 32'h0);
    chk("idle_en", 32'(en), 32'h1f);
    chk("idle_nops", 32'(nops), 32'h0);

    // md_ready while in RUN is ignored.
    md_ready = 1'b1;
    #1;
    chk("run_ready_sel", 32'(md_result_sel), 32'h0);
    chk("run_ready_en", 32'(en), 32'h1f);

    // Single load-use stall.
    next_cycle();
    clear_inputs();
    stall_lw = 1'b1;
    #1;
    chk("lw_en", 32'(en), 32'h07);
    chk("lw_nops", 32'(nops), 32'h2);
    next_cycle();
    clear_inputs();
    #1;
    chk("lw_after_en", 32'(en), 32'h1f);
    chk("lw_stall_cnt", 32'(stall_count), 32'd1);
    chk("lw_flush_cnt", 32'(flush_count), 32'd0);

    // Redirect beats the load-use stall.
    do_reset();
    redirect_x = 1'b1;
    stall_lw   = 1'b1;
    #1;
    chk("redir_en", 32'(en), 32'h1f);
    chk("redir_nops", 32'(nops), 32'h6);
    next_cycle();
    clear_inputs();
    #1;
    chk("redir_flush_cnt", 32'(flush_count), 32'd1);
    chk("redir_stall_cnt", 32'(stall_count), 32'd0);

    // mul/div with result at cycle 33; the instruction stays visible in DX
    // and unrelated hazards are raised mid-wait.
    do_reset();
    md_insn_x = 1'b1;
    #1;
    chk("md0_start", 32'(md_start), 32'h1);
    chk("md0_en", 32'(en), 32'h03);
    chk("md0_nops", 32'(nops), 32'h1);
    for (int c = 1; c <= 32; c++) begin
      next_cycle();
      redirect_x = (c == 5);
      stall_lw   = (c == 6);
      #1;
      chk($sformatf("mdw%0d_start", c), 32'(md_start), 32'h0);
      chk($sformatf("mdw%0d_en", c), 32'(en), 32'h03);
      chk($sformatf("mdw%0d_nops", c), 32'(nops), 32'h1);
    end
    next_cycle();
    md_ready = 1'b1;
    #1;
    chk("md33_sel", 32'(md_result_sel), 32'h1);
    chk("md33_en", 32'(en), 32'h1f);
    chk("md33_nops", 32'(nops), 32'h0);
    chk("md33_start", 32'(md_start), 32'h0);
    // Back-to-back second mul/div gets its own single start pulse.
    next_cycle();
    md_ready = 1'b0;
    #1;
    chk("md_b2b_start", 32'(md_start), 32'h1);
    chk("md_stall_cnt", 32'(stall_count), 32'd33);
    next_cycle();
    #1;
    chk("md_b2b_wait_start", 32'(md_start), 32'h0);
    next_cycle();
    md_insn_x = 1'b0;
    md_ready  = 1'b1;
    #1;
    chk("md_b2b_done_sel", 32'(md_result_sel), 32'h1);
    next_cycle();
    clear_inputs();
    #1;
    chk("md_b2b_stall_cnt", 32'(stall_count), 32'd35);

    // md_ready on the timeout cycle wins; no timeout recorded.
    do_reset();
    md_insn_x = 1'b1;
    for (int c = 1; c <= 39; c++) begin
      next_cycle();
      md_insn_x = 1'b0;
    end
    next_cycle();
    md_ready = 1'b1;
    #1;
    chk("tie_sel", 32'(md_result_sel), 32'h1);
    chk("tie_nops", 32'(nops), 32'h0);
    chk("tie_timeout", 32'(md_timeout), 32'h0);
    next_cycle();
    clear_inputs();
    #1;
    chk("tie_timeout_after", 32'(md_timeout), 32'h0);

    // Timeout with md_ready never arriving.
    do_reset();
    md_insn_x = 1'b1;
    for (int c = 1; c <= 39; c++) begin
      next_cycle();
      md_insn_x = 1'b0;
    end
    #1;
    chk("to39_en", 32'(en), 32'h03);
    chk("to39_timeout", 32'(md_timeout), 32'h0);
    next_cycle();
    #1;
    chk("to40_en", 32'(en), 32'h1f);
    chk("to40_nops", 32'(nops), 32'h1);
    chk("to40_sel", 32'(md_result_sel), 32'h0);
    chk("to40_timeout", 32'(md_timeout), 32'h1);
    next_cycle();
    #1;
    chk("to41_run_en", 32'(en), 32'h1f);
    chk("to41_nops", 32'(nops), 32'h0);
    chk("to41_stall_cnt", 32'(stall_count), 32'd40);
    next_cycle();
    next_cycle();
    #1;
    chk("to_sticky", 32'(md_timeout), 32'h1);

    // Reset during MD_WAIT (also clears the sticky timeout).
    md_insn_x = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      md_insn_x = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("midrst_en", 32'(en), 32'h1f);
    chk("midrst_nops", 32'(nops), 32'h0);
    next_cycle();
    reset = 1'b0;
    md_ready = 1'b1;
    #1;
    chk("midrst_run_en", 32'(en), 32'h1f);
    chk("midrst_late_ready_sel", 32'(md_result_sel), 32'h0);
    chk("midrst_stall_cnt", 32'(stall_count), 32'd0);
    chk("midrst_flush_cnt", 32'(flush_count), 32'd0);
    chk("midrst_timeout", 32'(md_timeout), 32'h0);

    // CNT_W=4 counter saturation.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      stall_lw4 = 1'b1;
      next_cycle();
      if (c == 13) chk("sat_cnt14", 32'(stall_count4), 32'd14);
    end
    clear_inputs();
    #1;
    chk("sat_cnt20", 32'(stall_count4), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
